// File: rtl/ksa_pipe_adder.sv
// ksa_pipe_adder: pipelined Kogge-Stone adder with a valid/ready handshake.
// Stage 0 registers the per-bit generate/propagate terms. Stages 1..LVL each
// register one prefix level, with spans of 1, 2, 4 and so on. The final stage
// registers sum, cout and ovf. Latency is LVL+2 cycles.
// Optional build macro KSA_PIPE_SUB_EN adds input sub_i. When sub_i=1 the block
// computes a + ~b + 1 and ignores cin_i.
module ksa_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef KSA_PIPE_SUB_EN
  input  logic             sub_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic [15:0]      res_cnt_o
);

  localparam int LVL = $clog2(WIDTH);

  // One Kogge-Stone prefix level: combine each position with the one span below.
  function automatic logic [2*WIDTH-1:0] ks_level(input logic [WIDTH-1:0] g,
                                                  input logic [WIDTH-1:0] p,
                                                  input int span);
    logic [WIDTH-1:0] go;
    logic [WIDTH-1:0] po;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= span) begin
        go[i] = g[i] | (p[i] & g[i-span]);
        po[i] = p[i] & p[i-span];
      end else begin
        go[i] = g[i];
        po[i] = p[i];
      end
    end
    return {go, po};
  endfunction

  logic             stall;
  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             sub_eff;
  logic [WIDTH-1:0] po_tmp;
  logic [WIDTH-1:0] carry;

  // Per-stage pipeline registers; index = stage number (0 = g/p, l = prefix level l)
  logic [LVL:0]     vld_p_q,  vld_p_d;
  logic [WIDTH-1:0] gen_p_q  [0:LVL];
  logic [WIDTH-1:0] gen_p_d  [0:LVL];
  logic [WIDTH-1:0] prp_p_q  [0:LVL-1];
  logic [WIDTH-1:0] prp_p_d  [0:LVL-1];
  logic [WIDTH-1:0] hsum_p_q [0:LVL];
  logic [WIDTH-1:0] hsum_p_d [0:LVL];
  logic [LVL:0]     cin_p_q,  cin_p_d;

  // Final (output) stage
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] sum_q,     sum_d;
  logic             cout_q,    cout_d;
  logic             ovf_q,     ovf_d;
  logic [15:0]      res_cnt_q, res_cnt_d;

`ifdef KSA_PIPE_SUB_EN
  assign sub_eff = sub_i;
`else
  assign sub_eff = 1'b0;
`endif

  // Next-state for every stage; the whole pipe moves together unless the output stalls
  always_comb begin
    stall   = out_vld_q && !out_ready_i;
    adv     = !stall;
    b_eff   = sub_eff ? ~b_i : b_i;
    cin_eff = sub_eff ? 1'b1 : cin_i;
    po_tmp  = '0;

    // stage 0: bitwise g/p; carry-in is absorbed into bit 0's generate so the
    // prefix tree only needs WIDTH positions and G[i] is directly carry out of bit i
    vld_p_d[0]     = in_valid_i;
    gen_p_d[0]     = a_i & b_eff;
    gen_p_d[0][0]  = (a_i[0] & b_eff[0]) | ((a_i[0] ^ b_eff[0]) & cin_eff);
    prp_p_d[0]     = a_i ^ b_eff;
    hsum_p_d[0]    = a_i ^ b_eff;
    cin_p_d[0]     = cin_eff;

    // stages 1..LVL: prefix levels with span 2^(l-1)
    for (int l = 1; l <= LVL; l++) begin
      {gen_p_d[l], po_tmp} = ks_level(gen_p_q[l-1], prp_p_q[l-1], 1 << (l - 1));
      if (l < LVL) prp_p_d[l] = po_tmp;
      hsum_p_d[l] = hsum_p_q[l-1];
      cin_p_d[l]  = cin_p_q[l-1];
      vld_p_d[l]  = vld_p_q[l-1];
    end

    // final stage: carries are the fully resolved group generates
    carry     = gen_p_q[LVL];
    out_vld_d = vld_p_q[LVL];
    sum_d     = hsum_p_q[LVL] ^ {carry[WIDTH-2:0], cin_p_q[LVL]};
    cout_d    = carry[WIDTH-1];
    ovf_d     = carry[WIDTH-1] ^ carry[WIDTH-2];
    res_cnt_d = res_cnt_q + {15'd0, (out_vld_q && out_ready_i)};
  end

  // Control and output registers: cleared by reset, held on stall
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      vld_p_q   <= '0;
      out_vld_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      res_cnt_q <= '0;
    end else begin
      if (adv) begin
        vld_p_q   <= vld_p_d;
        out_vld_q <= out_vld_d;
        sum_q     <= sum_d;
        cout_q    <= cout_d;
        ovf_q     <= ovf_d;
      end
      res_cnt_q <= res_cnt_d;
    end
  end

  // Datapath registers: no reset, only qualified by the valid bits beside them
  always_ff @(posedge wb_clk_i) begin
    if (adv) begin
      gen_p_q  <= gen_p_d;
      prp_p_q  <= prp_p_d;
      hsum_p_q <= hsum_p_d;
      cin_p_q  <= cin_p_d;
    end
  end

  // Ready is held high during reset so upstream never sees a stale stall
  assign in_ready_o  = wb_rst_i || !stall;
  assign out_valid_o = out_vld_q;
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;
  assign res_cnt_o   = res_cnt_q;

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// Testbench for ksa_pipe_adder (WIDTH=16): arithmetic reference model + directed vectors.
module tb_ksa_pipe_adder;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         wb_rst_i = 1'b1;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         cin_i = 1'b0;
  logic         sub_i = 1'b0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b1;
  logic [W-1:0] sum_o;
  logic         cout_o;
  logic         ovf_o;
  logic [15:0]  res_cnt_o;

  always #5 clk = ~clk;

  ksa_pipe_adder #(.WIDTH(W)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (wb_rst_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .cin_i      (cin_i),
`ifdef KSA_PIPE_SUB_EN
    .sub_i      (sub_i),
`endif
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .sum_o      (sum_o),
    .cout_o     (cout_o),
    .ovf_o      (ovf_o),
    .res_cnt_o  (res_cnt_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: plain integer addition; result packed as {ovf, cout, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full[W], full[W-1:0]};
  endfunction

  logic [W+1:0] exp_q[$];
  logic [W+1:0] held;
  logic         hold_pend = 1'b0;
  int           cnt_model = 0;
  int           cyc = 0;
  int           hs_count = 0;
  int           hs_first = 0;
  int           hs_last = 0;

  // Compare process: sampled on the falling edge, mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (wb_rst_i) begin
      chk("in_ready_in_reset", {63'd0, in_ready_o}, 64'd1);
      exp_q.delete();
      cnt_model = 0;
      hold_pend = 1'b0;
    end else begin
      chk("in_ready_vs_stall", {63'd0, in_ready_o}, {63'd0, !(out_valid_o && !out_ready_i)});
      chk("res_cnt", {48'd0, res_cnt_o}, cnt_model);
      if (hold_pend) begin
        chk("stall_hold_valid", {63'd0, out_valid_o}, 64'd1);
        chk("stall_hold_data", {{(62-W){1'b0}}, ovf_o, cout_o, sum_o}, {{(62-W){1'b0}}, held});
      end
      hold_pend = out_valid_o && !out_ready_i;
      held      = {ovf_o, cout_o, sum_o};
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) chk("spurious_output", {63'd0, out_valid_o}, 64'd0);
        else chk("result", {{(62-W){1'b0}}, ovf_o, cout_o, sum_o},
                 {{(62-W){1'b0}}, exp_q.pop_front()});
        cnt_model = (cnt_model + 1) & 16'hFFFF;
        if (hs_count == 0) hs_first = cyc;
        hs_last = cyc;
        hs_count++;
      end
      if (in_valid_i && in_ready_o) exp_q.push_back(model(a_i, b_i, cin_i, sub_i));
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    wb_rst_i   = 1'b1;
    @(posedge clk); #1;
    wb_rst_i   = 1'b0;
  endtask

  // One beat into an empty pipe: check latency and hand-computed result
  task automatic single_beat(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic sub, input logic [W-1:0] es,
                             input logic ec, input logic eo);
    int  lat;
    bit  seen;
    @(posedge clk); #1;
    a_i = a; b_i = b; cin_i = cin; sub_i = sub;
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    lat = 0; seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      lat++;
      if (out_valid_o) seen = 1;
    end
    if (!seen) lat = 99;
    chk({nm, "_latency"}, lat, 6);
    chk({nm, "_sum"}, {48'd0, sum_o}, {48'd0, es});
    chk({nm, "_cout"}, {63'd0, cout_o}, {63'd0, ec});
    chk({nm, "_ovf"}, {63'd0, ovf_o}, {63'd0, eo});
    @(posedge clk); #1;
    sub_i = 1'b0;
  endtask

  initial begin
    int sent;
    int guard;
    bit acc;
    int stale;

    // reset state
    repeat (3) @(posedge clk);
    #1 wb_rst_i = 1'b0;
    chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    chk("rst_sum", {48'd0, sum_o}, 64'd0);
    chk("rst_cout", {63'd0, cout_o}, 64'd0);
    chk("rst_ovf", {63'd0, ovf_o}, 64'd0);
    chk("rst_res_cnt", {48'd0, res_cnt_o}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready_o}, 64'd1);

    // directed vectors
    single_beat("ffff_p_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    single_beat("7fff_p_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    single_beat("cin_mid",  16'h1234, 16'h0FF0, 1'b1, 1'b0, 16'h2225, 1'b0, 1'b0);
    single_beat("neg_ovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    single_beat("cin_rip",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef KSA_PIPE_SUB_EN
    single_beat("sub_5_7",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    single_beat("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    // 100 back-to-back beats, sink always ready
    do_reset();
    hs_count = 0;
    for (int i = 0; i < 100; i++) begin
      a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom);
`ifdef KSA_PIPE_SUB_EN
      sub_i = 1'($urandom);
`endif
      in_valid_i = 1'b1;
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin @(posedge clk); #1; guard++; end
    chk("stream_drained", exp_q.size(), 0);
    chk("stream_count", hs_count, 100);
    chk("stream_contiguous", hs_last - hs_first + 1, 100);
    chk("stream_res_cnt", {48'd0, res_cnt_o}, 64'd100);

    // random backpressure
    sent = 0; guard = 0;
    while (sent < 150 && guard < 3000) begin
      a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom);
`ifdef KSA_PIPE_SUB_EN
      sub_i = 1'($urandom);
`endif
      in_valid_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid_i && in_ready_o;
      @(posedge clk); #1;
      out_ready_i = 1'($urandom);
      if (acc) sent++;
      guard++;
    end
    chk("bp_all_sent", sent, 150);
    in_valid_i = 1'b0; out_ready_i = 1'b1; sub_i = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin @(posedge clk); #1; guard++; end
    chk("bp_drained", exp_q.size(), 0);

    // reset with 4 beats in flight
    for (int i = 0; i < 4; i++) begin
      a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'b0;
      in_valid_i = 1'b1;
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    wb_rst_i = 1'b1;
    @(posedge clk); #1;
    wb_rst_i = 1'b0;
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid_o) stale++;
      @(posedge clk); #1;
    end
    chk("midrst_stale_valid", stale, 0);
    chk("midrst_res_cnt", {48'd0, res_cnt_o}, 64'd0);
    single_beat("after_rst", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ksa_pipe_adder.md
KSA_PIPE_ADDER -- requirements
Module: ksa_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand width; SHALL be a power of two in the range 8..64.
REQ-002 Parameter LVL (derived localparam, log2(WIDTH)): number of Kogge-Stone prefix levels.
REQ-003 wb_clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 wb_rst_i  in  1  reset, synchronous and active-high.
REQ-005 in_valid_i  in  1  operand beat valid.
REQ-006 in_ready_o  out  1  block accepts an operand beat this cycle.
REQ-007 a_i, b_i  in  WIDTH each  operands.
REQ-008 cin_i  in  1  carry-in.
REQ-009 out_valid_o  out  1  result valid.
REQ-010 out_ready_i  in  1  downstream accepts the result.
REQ-011 sum_o  out  WIDTH  result sum.
REQ-012 cout_o  out  1  carry-out.
REQ-013 ovf_o  out  1  two's-complement signed overflow.
REQ-014 res_cnt_o  out  16  count of completed output handshakes.

Function
REQ-015 Accept occurs when in_valid_i && in_ready_o; output handshake occurs when out_valid_o && out_ready_i.
REQ-016 Pipeline: stage 0 registers per-bit g=a&b and p=a^b plus cin; stages 1..LVL each register one prefix level (span 1,2,4,...); the final stage registers sum, cout and ovf.
REQ-017 Latency: LVL+2 cycles from accept to out_valid_o, which is 6 for WIDTH=16; throughput is one beat per cycle when not stalled.
REQ-018 Carry-in is folded in as generate of bit -1: c[-1]=cin; sum[i]=p[i]^c[i-1]; cout=c[WIDTH-1].
REQ-019 ovf_o=c[WIDTH-1]^c[WIDTH-2] for the same beat.
REQ-020 Each stage carries a valid bit; bubbles propagate as invalid and never produce output.
REQ-021 Stall is global: stall = out_valid_o && !out_ready_i; while stalled, every stage holds its contents and in_ready_o=0.
REQ-022 in_ready_o = !stall. It is combinational from out_ready_i and out_valid_o, and never depends on in_valid_i.
REQ-023 A simultaneous output handshake and accept in one cycle advances the whole pipeline; no beat is lost or duplicated.
REQ-024 sum_o, cout_o and ovf_o remain stable while out_valid_o=1 and out_ready_i=0.
REQ-025 res_cnt_o increments by 1 per output handshake and wraps from 0xFFFF to 0x0000.

Reset
REQ-026 When wb_rst_i=1 at a clock edge, all stage valid bits clear, out_valid_o=0, sum_o=0, cout_o=0, ovf_o=0 and res_cnt_o=0.
REQ-027 Beats in flight are discarded when reset is asserted mid-operation; in_ready_o=1 while in reset and on the first cycle after reset.
REQ-028 Operand and data registers need no reset beyond the output registers named in REQ-026.

Configuration
REQ-029 Macro KSA_PIPE_SUB_EN adds input port sub_i (1 bit), sampled with the operands at accept.
REQ-030 With KSA_PIPE_SUB_EN defined and sub_i=1, the effective operation is a + ~b + 1, with cin_i ignored; cout_o=1 means no borrow; ovf_o flags signed subtract overflow.
REQ-031 Without KSA_PIPE_SUB_EN, port sub_i does not exist and the block performs addition only; latency is identical in both builds.

Verification (WIDTH=16)
REQ-032 a=0xFFFF, b=0x0001, cin=0, single beat -> 6 cycles later out_valid_o=1, sum_o=0x0000, cout_o=1, ovf_o=0.
REQ-033 a=0x7FFF, b=0x0001, cin=0 -> sum_o=0x8000, cout_o=0, ovf_o=1.
REQ-034 Stream 100 random beats back-to-back with out_ready_i=1 -> 100 correct results in order, one per cycle, res_cnt_o=100.
REQ-035 Stream with out_ready_i toggled pseudo-randomly -> in_ready_o=0 exactly when stalled, outputs held stable, no loss or duplication, order preserved.
REQ-036 Assert wb_rst_i for one cycle with 4 beats in flight -> no stale out_valid_o afterwards, res_cnt_o=0, and the next beat completes with 6-cycle latency.
REQ-037 With KSA_PIPE_SUB_EN: a=0x0005, b=0x0007, sub_i=1 -> sum_o=0xFFFE, cout_o=0; a=0x8000, b=0x0001, sub_i=1 -> sum_o=0x7FFF, ovf_o=1.
